// File: rtl/core_pkg.sv
// Shared types and constants for the core front end: fetch FSM states,
// instruction size and the default reset PC.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } pc_state_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: sequential or branch/jump target, with JALR bit-0 clear.
// Alignment handling depends on PC_MISALIGN_TRAP_EN.
module pc_next_calc import core_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_source_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            jalr_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] raw;

  assign tgt = jalr_i ? (target_i & ~XLEN'(1)) : target_i;
  // Sequential step wraps naturally at 2^XLEN.
  assign raw = pc_source_i ? tgt : pc_i + XLEN'(INSTR_BYTES);

`ifdef PC_MISALIGN_TRAP_EN
  assign next_pc_o    = raw;
  assign misaligned_o = pc_source_i && (tgt[1:0] != 2'b00);
`else
  assign next_pc_o    = raw & ~XLEN'(3);
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch handshake FSM and retired-instruction counter.
// Optional misaligned-target trap enabled by PC_MISALIGN_TRAP_EN.
module pc_fetch_unit import core_pkg::*; #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int              CNT_W    = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pc_source_i,
  input  logic [XLEN-1:0]  target_i,
  input  logic             jalr_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_ready_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             instr_valid_o,
  output logic [31:0]      instr_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             trap_o,
  output logic [XLEN-1:0]  trap_addr_o
);

  pc_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]  next_pc;
  logic             misaligned;

  pc_next_calc #(.XLEN(XLEN)) u_next (
    .pc_i         (pc_q),
    .pc_source_i  (pc_source_i),
    .target_i     (target_i),
    .jalr_i       (jalr_i),
    .next_pc_o    (next_pc),
    .misaligned_o (misaligned)
  );

  // Strobes decode straight from the state register; no input reaches an output.
  assign imem_req_o    = (state_q == FETCH);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == EXEC);
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign instret_o     = instret_q;

`ifdef PC_MISALIGN_TRAP_EN
  logic [XLEN-1:0] trap_addr_q, trap_addr_d;
  assign trap_o      = (state_q == TRAP);
  assign trap_addr_o = trap_addr_q;
`else
  assign trap_o      = 1'b0;
  assign trap_addr_o = '0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
`ifdef PC_MISALIGN_TRAP_EN
    trap_addr_d = trap_addr_q;
`endif
    unique case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (imem_ready_i) begin
          instr_d = imem_rdata_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (misaligned) begin
          // Faulting instruction does not retire; PC stays on it.
          state_d = TRAP;
`ifdef PC_MISALIGN_TRAP_EN
          trap_addr_d = next_pc;
`endif
        end else begin
          pc_d      = next_pc;
          instret_d = instret_q + CNT_W'(1);
          state_d   = FETCH;
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_addr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
`ifdef PC_MISALIGN_TRAP_EN
      trap_addr_q <= trap_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle vector table with a
// scoreboard queue, plus hand-written reset-during-fetch and bounded-wait sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_source;
  logic [31:0] target;
  logic        jalr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [63:0] instret;
  logic        trap;
  logic [31:0] trap_addr;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(64)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_source_i   (pc_source),
    .target_i      (target),
    .jalr_i        (jalr),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ready_i  (imem_ready),
    .imem_rdata_i  (imem_rdata),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .pc_o          (pc),
    .instret_o     (instret),
    .trap_o        (trap),
    .trap_addr_o   (trap_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        chk;
    logic        rdy;
    logic [31:0] rdata;
    logic        src;
    logic [31:0] tgt;
    logic        jalr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_cnt;
    logic        e_trap;
    logic [31:0] e_taddr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic vec_t V(logic r, logic c, logic rdy, logic [31:0] rd, logic src,
                             logic [31:0] tgt, logic jl, logic req, logic [31:0] addr,
                             logic vld, logic [31:0] ins, logic [63:0] cnt, logic tr,
                             logic [31:0] ta);
    vec_t v;
    v.rst = r; v.chk = c; v.rdy = rdy; v.rdata = rd; v.src = src; v.tgt = tgt;
    v.jalr = jl; v.e_req = req; v.e_addr = addr; v.e_valid = vld; v.e_instr = ins;
    v.e_cnt = cnt; v.e_trap = tr; v.e_taddr = ta;
    return v;
  endfunction

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge; expected outputs go through the scoreboard.
  task automatic apply(vec_t v, string tag);
    vec_t e;
    @(negedge clk);
    rst = v.rst; imem_ready = v.rdy; imem_rdata = v.rdata;
    pc_source = v.src; target = v.tgt; jalr = v.jalr;
    if (v.chk) sb.push_back(v);
    #1;
    if (v.chk && sb.size() > 0) begin
      e = sb.pop_front();
      cmp({tag, ".req"},     {63'd0, imem_req},    {63'd0, e.e_req});
      cmp({tag, ".addr"},    {32'd0, imem_addr},   {32'd0, e.e_addr});
      cmp({tag, ".pc"},      {32'd0, pc},          {32'd0, e.e_addr});
      cmp({tag, ".valid"},   {63'd0, instr_valid}, {63'd0, e.e_valid});
      cmp({tag, ".instr"},   {32'd0, instr},       {32'd0, e.e_instr});
      cmp({tag, ".instret"}, instret,              e.e_cnt);
      cmp({tag, ".trap"},    {63'd0, trap},        {63'd0, e.e_trap});
      cmp({tag, ".taddr"},   {32'd0, trap_addr},   {32'd0, e.e_taddr});
    end
  endtask

  initial begin
    rst = 1'b1; pc_source = 1'b0; target = '0; jalr = 1'b0;
    imem_ready = 1'b0; imem_rdata = '0;

    //        rst chk rdy rdata         src tgt           jl  req addr          vld instr         cnt tr ta
    tbl.push_back(V(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(V(1, 1, 1, 32'hBAD,      1, 32'h500,      0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(V(0, 1, 1, 32'hBAD,      1, 32'h500,      0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0)); // BOOT ignores ready
    tbl.push_back(V(0, 1, 1, NOP,          1, 32'h500,      0, 1, 32'h0,        0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(V(0, 1, 1, 32'hBAD,      0, 32'h0,        0, 0, 32'h0,        1, NOP,          0, 0, 32'h0));
    tbl.push_back(V(0, 1, 1, NOP,          0, 32'h0,        0, 1, 32'h4,        0, NOP,          1, 0, 32'h0));
    tbl.push_back(V(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h4,        1, NOP,          1, 0, 32'h0));
    tbl.push_back(V(0, 1, 1, NOP,          0, 32'h0,        0, 1, 32'h8,        0, NOP,          2, 0, 32'h0));
    tbl.push_back(V(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8,        1, NOP,          2, 0, 32'h0));
    // three wait states then ready
    tbl.push_back(V(0, 1, 0, 32'hDEAD,     0, 32'h0,        0, 1, 32'hC,        0, NOP,          3, 0, 32'h0));
    tbl.push_back(V(0, 1, 0, 32'hDEAD,     1, 32'h700,      0, 1, 32'hC,        0, NOP,          3, 0, 32'h0));
    tbl.push_back(V(0, 1, 0, 32'hDEAD,     0, 32'h0,        0, 1, 32'hC,        0, NOP,          3, 0, 32'h0));
    tbl.push_back(V(0, 1, 1, 32'hAAAA0013, 0, 32'h0,        0, 1, 32'hC,        0, NOP,          3, 0, 32'h0));
    tbl.push_back(V(0, 1, 0, 32'h0,        1, 32'h100,      0, 0, 32'hC,        1, 32'hAAAA0013, 3, 0, 32'h0));
    tbl.push_back(V(0, 1, 1, NOP,          0, 32'h0,        0, 1, 32'h100,      0, 32'hAAAA0013, 4, 0, 32'h0));
    tbl.push_back(V(0, 1, 0, 32'h0,        0, 32'h300,      0, 0, 32'h100,      1, NOP,          4, 0, 32'h0));
    tbl.push_back(V(0, 1, 1, NOP,          0, 32'h0,        0, 1, 32'h104,      0, NOP,          5, 0, 32'h0));
    tbl.push_back(V(0, 1, 0, 32'h0,        1, 32'h201,      1, 0, 32'h104,      1, NOP,          5, 0, 32'h0));
    tbl.push_back(V(0, 1, 1, NOP,          0, 32'h0,        0, 1, 32'h200,      0, NOP,          6, 0, 32'h0));
    tbl.push_back(V(0, 1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 0, 32'h200,      1, NOP,          6, 0, 32'h0));
    tbl.push_back(V(0, 1, 1, NOP,          0, 32'h0,        0, 1, 32'hFFFFFFFC, 0, NOP,          7, 0, 32'h0));
    tbl.push_back(V(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'hFFFFFFFC, 1, NOP,          7, 0, 32'h0));
    tbl.push_back(V(0, 1, 1, NOP,          0, 32'h0,        0, 1, 32'h0,        0, NOP,          8, 0, 32'h0));
    tbl.push_back(V(0, 1, 0, 32'h0,        1, 32'h102,      0, 0, 32'h0,        1, NOP,          8, 0, 32'h0));
`ifdef PC_MISALIGN_TRAP_EN
    tbl.push_back(V(0, 1, 1, 32'hBAD,      1, 32'h400,      0, 0, 32'h0,        0, NOP,          8, 1, 32'h102));
    tbl.push_back(V(0, 1, 1, 32'hBAD,      0, 32'h0,        0, 0, 32'h0,        0, NOP,          8, 1, 32'h102));
`else
    tbl.push_back(V(0, 1, 0, 32'hBAD,      1, 32'h400,      0, 1, 32'h100,      0, NOP,          9, 0, 32'h0));
    tbl.push_back(V(0, 1, 0, 32'hBAD,      0, 32'h0,        0, 1, 32'h100,      0, NOP,          9, 0, 32'h0));
`endif

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    // Reset while a fetch is waiting: the late ready must not be captured.
    apply(V(1, 0, 0, 32'h0,    0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0), "r0");
    apply(V(0, 1, 0, 32'h0,    0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0), "r1");
    apply(V(0, 1, 0, 32'h0,    0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 32'h0), "r2");
    apply(V(1, 1, 1, 32'h1234, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 32'h0), "r3");
    apply(V(0, 1, 1, 32'h5678, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0), "r4");
    apply(V(0, 1, 0, 32'h0,    0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 32'h0), "r5");

    // Bounded wait for the next instruction to reach execute.
    begin
      bit seen = 1'b0;
      @(negedge clk);
      imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        imem_ready = 1'b0; pc_source = 1'b0;
        #1;
        if (instr_valid) seen = 1'b1;
      end
      cmp("wait.valid_seen", {63'd0, seen}, 64'd1);
      cmp("wait.instr", {32'd0, instr}, 64'h0050_0093);
      @(negedge clk); #1;
      cmp("wait.next_addr", {32'd0, imem_addr}, 64'h4);
      cmp("wait.instret", instret, 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
